counter_mc: RTL and testbench

Multi-channel, mode-programmable successor to the single-channel `counter` used under `tb_top`. It holds `NUM_CH` independent counters, each with a run-time terminal value and one of three modes: wrap, one-shot, or up/down. Each channel produces a terminal-event pulse, and one-shot channels also produce a sticky done flag. Reset configuration reproduces the legacy free-running counter on every channel, so existing DPI test flows keep working by instantiating it with `NUM_CH=1`.

---
 rtl/counter_mc_pkg.sv | 14 +
 rtl/counter_mc_ch.sv | 131 +++++++++++++
 rtl/counter_mc.sv | 60 ++++++
 tb/tb_counter_mc.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_mc_pkg.sv
// Shared types and constants for the multi-channel counter.
package dut_package;

    localparam int CNT_WIDTH  = 8;
    localparam int CNT_MAX_CH = 16;

    typedef enum logic [1:0] {
        CNT_WRAP    = 2'd0,
        CNT_ONESHOT = 2'd1,
        CNT_UPDOWN  = 2'd2,
        CNT_RSVD    = 2'd3
    } cnt_mode_t;

endpackage

// File: rtl/counter_mc_ch.sv
// One counter channel: programmable terminal value, wrap / one-shot / up-down.
//
// state (dir, done) | meaning
// ------------------+-------------------------------------------------
// (up,   0)         | counting toward limit (all modes)
// (down, 0)         | UPDOWN only: counting back toward 0
// (up,   1)         | ONESHOT only: terminal reached, frozen until clr/cfg
module counter_ch
    import dut_package::*;
#(
    parameter int W = CNT_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_en,
    input  logic            i_clr,
    input  logic            i_cfg_we,
    input  logic [W-1:0]    i_cfg_limit,
    input  cnt_mode_t       i_cfg_mode,
    output logic [W-1:0]    o_cnt,
    output logic            o_end,
    output logic            o_done,
    output logic            o_end_nxt
);

    logic [W-1:0] r_cnt;
    logic [W-1:0] r_limit;
    cnt_mode_t    r_mode;
    logic         r_dir;
    logic         r_done;
    logic         r_end;

    logic [W-1:0] w_cnt_nxt;
    logic [W-1:0] w_limit_nxt;
    cnt_mode_t    w_mode_nxt;
    logic         w_dir_nxt;
    logic         w_done_nxt;
    logic         w_end_nxt;

    // Next-state decode: clear beats configuration, configuration beats counting.
    // Comparisons use >= / < so a stale cnt above limit can never run past it.
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_limit_nxt = r_limit;
        w_mode_nxt  = r_mode;
        w_dir_nxt   = r_dir;
        w_done_nxt  = r_done;
        w_end_nxt   = 1'b0;
        if (i_clr) begin
            w_cnt_nxt  = '0;
            w_dir_nxt  = 1'b0;
            w_done_nxt = 1'b0;
        end else if (i_cfg_we) begin
            w_limit_nxt = i_cfg_limit;
            w_mode_nxt  = i_cfg_mode;
            w_cnt_nxt   = '0;
            w_dir_nxt   = 1'b0;
            w_done_nxt  = 1'b0;
        end else if (i_en) begin
            case (r_mode)
                CNT_ONESHOT: begin
                    if (!r_done) begin
                        if (r_cnt < r_limit) begin
                            w_cnt_nxt = r_cnt + W'(1);
                        end else begin
                            w_done_nxt = 1'b1;
                            w_end_nxt  = 1'b1;
                        end
                    end
                end
                CNT_UPDOWN: begin
                    if (r_limit == '0) begin
                        // Degenerate bounce: stay at 0, event every enabled cycle.
                        w_cnt_nxt = '0;
                        w_end_nxt = 1'b1;
                    end else if (!r_dir) begin
                        if (r_cnt < r_limit) begin
                            w_cnt_nxt = r_cnt + W'(1);
                        end else begin
                            w_dir_nxt = 1'b1;
                            w_cnt_nxt = r_limit - W'(1);
                            w_end_nxt = 1'b1;
                        end
                    end else begin
                        if (r_cnt != '0) begin
                            w_cnt_nxt = r_cnt - W'(1);
                        end else begin
                            w_dir_nxt = 1'b0;
                            w_cnt_nxt = W'(1);
                            w_end_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                    // WRAP, and the reserved encoding behaves the same way.
                    if (r_cnt < r_limit) begin
                        w_cnt_nxt = r_cnt + W'(1);
                    end else begin
                        w_cnt_nxt = '0;
                        w_end_nxt = 1'b1;
                    end
                end
            endcase
        end
    end

    // Channel state register with synchronous reset to the free-running default.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_limit <= '1;
            r_mode  <= CNT_WRAP;
            r_dir   <= 1'b0;
            r_done  <= 1'b0;
            r_end   <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_limit <= w_limit_nxt;
            r_mode  <= w_mode_nxt;
            r_dir   <= w_dir_nxt;
            r_done  <= w_done_nxt;
            r_end   <= w_end_nxt;
        end
    end

    assign o_cnt     = r_cnt;
    assign o_end     = r_end;
    assign o_done    = r_done;
    assign o_end_nxt = w_end_nxt;

endmodule

// File: rtl/counter_mc.sv
// Multi-channel mode-programmable counter; reset state matches the legacy
// single free-running counter on every channel.
module counter_mc
    import dut_package::*;
#(
    parameter  int NUM_CH    = 4,
    parameter  int CNT_WIDTH = dut_package::CNT_WIDTH,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0]           flag_cnt_i,
    input  logic [NUM_CH-1:0]           clr_i,
    input  logic                        cfg_we_i,
    input  logic [CH_W-1:0]             cfg_ch_i,
    input  logic [CNT_WIDTH-1:0]        cfg_limit_i,
    input  logic [1:0]                  cfg_mode_i,
    output logic [NUM_CH*CNT_WIDTH-1:0] cnt_o,
    output logic [NUM_CH-1:0]           end_cnt_o,
    output logic [NUM_CH-1:0]           done_o,
    output logic                        any_end_o
);

    logic [NUM_CH-1:0] w_cfg_hit;
    logic [NUM_CH-1:0] w_end_nxt;
    logic              r_any_end;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        // Full-width compare: a select at or beyond NUM_CH matches no channel.
        assign w_cfg_hit[gi] = cfg_we_i && (int'(cfg_ch_i) == gi);

        counter_ch #(
            .W (CNT_WIDTH)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .i_en        (flag_cnt_i[gi]),
            .i_clr       (clr_i[gi]),
            .i_cfg_we    (w_cfg_hit[gi]),
            .i_cfg_limit (cfg_limit_i),
            .i_cfg_mode  (cnt_mode_t'(cfg_mode_i)),
            .o_cnt       (cnt_o[gi*CNT_WIDTH +: CNT_WIDTH]),
            .o_end       (end_cnt_o[gi]),
            .o_done      (done_o[gi]),
            .o_end_nxt   (w_end_nxt[gi])
        );
    end

    // Aggregate event, registered from next-state so it lines up with end_cnt_o.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_any_end <= 1'b0;
        end else begin
            r_any_end <= |w_end_nxt;
        end
    end

    assign any_end_o = r_any_end;

endmodule

// File: tb/tb_counter_mc.sv
// Scoreboard bench for counter_mc: a 4-channel instance for the mode tests and
// a 1-channel instance for the legacy free-running default.
module tb_counter_mc;
    import dut_package::*;

    localparam int W = CNT_WIDTH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [3:0]   a_en, a_clr, a_end, a_done;
    logic         a_we, a_any;
    logic [1:0]   a_ch, a_mode;
    logic [W-1:0] a_lim;
    logic [4*W-1:0] a_cnt;

    logic         b_en, b_clr, b_we, b_ch, b_end, b_done, b_any;
    logic [1:0]   b_mode;
    logic [W-1:0] b_lim, b_cnt;

    counter_mc #(.NUM_CH(4), .CNT_WIDTH(W)) u_dut (
        .clk(clk), .rst(rst), .flag_cnt_i(a_en), .clr_i(a_clr),
        .cfg_we_i(a_we), .cfg_ch_i(a_ch), .cfg_limit_i(a_lim), .cfg_mode_i(a_mode),
        .cnt_o(a_cnt), .end_cnt_o(a_end), .done_o(a_done), .any_end_o(a_any)
    );

    counter_mc #(.NUM_CH(1), .CNT_WIDTH(W)) u_one (
        .clk(clk), .rst(rst), .flag_cnt_i(b_en), .clr_i(b_clr),
        .cfg_we_i(b_we), .cfg_ch_i(b_ch), .cfg_limit_i(b_lim), .cfg_mode_i(b_mode),
        .cnt_o(b_cnt), .end_cnt_o(b_end), .done_o(b_done), .any_end_o(b_any)
    );

    typedef struct {
        string tag;
        bit    inst;
        int    ch;
        int    cnt;
        int    endp;
        int    done;
        int    any;   // -1: not checked
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;
    int n0    = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input bit inst, input int ch,
                           input int cnt, input int endp, input int done, input int any);
        exp_t e;
        e.tag = tag; e.inst = inst; e.ch = ch; e.cnt = cnt;
        e.endp = endp; e.done = done; e.any = any;
        sb.push_back(e);
    endtask

    // Channel 0 of u_dut free-runs with the default limit for the whole mode section.
    task automatic ch0();
        n0++;
        sb_push("ch0", 1'b0, 0, n0 % 256, (n0 % 256 == 0), 0, -1);
    endtask

    // Clock the DUTs once, then drain the scoreboard against the outputs.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.inst == 1'b0) begin
                chk({e.tag, ".cnt"},  int'(a_cnt[e.ch*W +: W]), e.cnt);
                chk({e.tag, ".end"},  int'(a_end[e.ch]),  e.endp);
                chk({e.tag, ".done"}, int'(a_done[e.ch]), e.done);
                if (e.any >= 0) chk({e.tag, ".any"}, int'(a_any), e.any);
            end else begin
                chk({e.tag, ".cnt"},  int'(b_cnt),  e.cnt);
                chk({e.tag, ".end"},  int'(b_end),  e.endp);
                chk({e.tag, ".done"}, int'(b_done), e.done);
                if (e.any >= 0) chk({e.tag, ".any"}, int'(b_any), e.any);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int ud_cnt [8] = '{1, 2, 3, 2, 1, 0, 1, 2};
        int ud_end [8] = '{0, 0, 0, 1, 0, 0, 1, 0};
        int pat    [3] = '{1, 0, 1};

        rst = 1'b1;
        a_en = '0; a_clr = '0; a_we = 1'b0; a_ch = '0; a_lim = '0; a_mode = '0;
        b_en = 1'b0; b_clr = 1'b0; b_we = 1'b0; b_ch = 1'b0; b_lim = '0; b_mode = '0;
        @(negedge clk);

        for (int c = 0; c < 4; c++) sb_push("rst", 1'b0, c, 0, 0, 0, 0);
        sb_push("rst_one", 1'b1, 0, 0, 0, 0, 0);
        tick();

        rst = 1'b0;
        a_en = 4'b0001;
        ch0();
        for (int c = 1; c < 4; c++) sb_push("idle", 1'b0, c, 0, 0, 0, -1);
        tick();

        // WRAP on channel 2, limit 5
        a_en = 4'b0101; a_we = 1'b1; a_ch = 2'd2; a_lim = 8'd5; a_mode = CNT_WRAP;
        ch0();
        sb_push("wrap_cfg", 1'b0, 2, 0, 0, 0, 0);
        sb_push("wrap_ch1", 1'b0, 1, 0, 0, 0, -1);
        tick();
        a_we = 1'b0;
        for (int j = 1; j <= 13; j++) begin
            ch0();
            sb_push("wrap", 1'b0, 2, j % 6, (j % 6 == 0), 0, (j % 6 == 0));
            sb_push("wrap_ch1", 1'b0, 1, 0, 0, 0, -1);
            sb_push("wrap_ch3", 1'b0, 3, 0, 0, 0, -1);
            tick();
        end

        // ONESHOT on channel 1, limit 3, then clear and restart
        a_en = 4'b0011; a_we = 1'b1; a_ch = 2'd1; a_lim = 8'd3; a_mode = CNT_ONESHOT;
        ch0();
        sb_push("os_cfg", 1'b0, 1, 0, 0, 0, 0);
        sb_push("os_ch2", 1'b0, 2, 1, 0, 0, -1);
        tick();
        a_we = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            ch0();
            sb_push("os", 1'b0, 1, (j < 3) ? j : 3, (j == 4), (j >= 4), (j == 4));
            tick();
        end
        a_clr = 4'b0010;
        ch0();
        sb_push("os_clr", 1'b0, 1, 0, 0, 0, 0);
        tick();
        a_clr = 4'b0000;
        for (int j = 1; j <= 2; j++) begin
            ch0();
            sb_push("os_restart", 1'b0, 1, j, 0, 0, 0);
            tick();
        end

        // Reserved mode 3 on channel 1 counts as WRAP, limit 2
        a_we = 1'b1; a_ch = 2'd1; a_lim = 8'd2; a_mode = 2'd3;
        ch0();
        sb_push("rsvd_cfg", 1'b0, 1, 0, 0, 0, 0);
        tick();
        a_we = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            ch0();
            sb_push("rsvd", 1'b0, 1, j % 3, (j % 3 == 0), 0, (j % 3 == 0));
            tick();
        end

        // UPDOWN on channel 3, limit 3
        a_en = 4'b1001; a_we = 1'b1; a_ch = 2'd3; a_lim = 8'd3; a_mode = CNT_UPDOWN;
        ch0();
        sb_push("ud_cfg", 1'b0, 3, 0, 0, 0, 0);
        tick();
        a_we = 1'b0;
        for (int j = 0; j < 8; j++) begin
            ch0();
            sb_push("ud", 1'b0, 3, ud_cnt[j], ud_end[j], 0, ud_end[j]);
            tick();
        end

        // limit 0 on channels 1 (ONESHOT), 2 (WRAP), 3 (UPDOWN)
        a_en = 4'b0001; a_we = 1'b1; a_lim = 8'd0;
        a_ch = 2'd1; a_mode = CNT_ONESHOT; ch0(); sb_push("z_cfg1", 1'b0, 1, 0, 0, 0, 0); tick();
        a_ch = 2'd2; a_mode = CNT_WRAP;    ch0(); sb_push("z_cfg2", 1'b0, 2, 0, 0, 0, 0); tick();
        a_ch = 2'd3; a_mode = CNT_UPDOWN;  ch0(); sb_push("z_cfg3", 1'b0, 3, 0, 0, 0, 0); tick();
        a_we = 1'b0;
        a_en = 4'b1111;
        for (int j = 1; j <= 3; j++) begin
            ch0();
            sb_push("z_os", 1'b0, 1, 0, (j == 1), 1, 1);
            sb_push("z_wrap", 1'b0, 2, 0, 1, 0, -1);
            sb_push("z_ud", 1'b0, 3, 0, 1, 0, -1);
            tick();
        end
        for (int j = 0; j < 3; j++) begin
            a_en = 4'b0001 | 4'(pat[j] << 2);
            ch0();
            sb_push("z_toggle", 1'b0, 2, 0, pat[j], 0, pat[j]);
            sb_push("z_os_hold", 1'b0, 1, 0, 0, 1, -1);
            tick();
        end

        // Clear and configuration write on channel 3 in the same cycle: clear wins
        a_en = 4'b1001; a_clr = 4'b1000;
        a_we = 1'b1; a_ch = 2'd3; a_lim = 8'd9; a_mode = CNT_WRAP;
        ch0();
        sb_push("conf_clr", 1'b0, 3, 0, 0, 0, 0);
        tick();
        a_clr = 4'b0000; a_we = 1'b0;
        for (int j = 1; j <= 2; j++) begin
            ch0();
            sb_push("conf_keep", 1'b0, 3, 0, 1, 0, 1);
            tick();
        end

        // rst mid-UPDOWN
        a_we = 1'b1; a_ch = 2'd3; a_lim = 8'd3; a_mode = CNT_UPDOWN;
        ch0();
        sb_push("rm_cfg", 1'b0, 3, 0, 0, 0, 0);
        tick();
        a_we = 1'b0;
        for (int j = 1; j <= 2; j++) begin
            ch0();
            sb_push("rm_run", 1'b0, 3, j, 0, 0, 0);
            tick();
        end
        rst = 1'b1; a_en = 4'b1111;
        for (int c = 0; c < 4; c++) sb_push("rm_rst", 1'b0, c, 0, 0, 0, 0);
        tick();
        rst = 1'b0; a_en = 4'b1001; n0 = 0;
        for (int j = 1; j <= 4; j++) begin
            ch0();
            sb_push("rm_after", 1'b0, 3, j, 0, 0, 0);
            sb_push("rm_ch1", 1'b0, 1, 0, 0, 0, -1);
            tick();
        end
        a_en = 4'b0000;

        // Single channel: legacy free-running default, with an out-of-range write mid-run
        b_en = 1'b1;
        for (int j = 1; j <= 300; j++) begin
            if (j == 10) begin
                b_we = 1'b1; b_ch = 1'b1; b_lim = 8'd5; b_mode = CNT_ONESHOT;
            end else begin
                b_we = 1'b0;
            end
            sb_push("one", 1'b1, 0, j % 256, (j % 256 == 0), 0, (j % 256 == 0));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
